// File: rtl/aes_round_sequencer.sv
// Control/next-state stage of the iterative AES-128 core: accepts a plaintext/key pair,
// steps the external round datapath one round per clk, then holds the ciphertext for downstream.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int DATA_W     = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] plaintext,
    input  logic [DATA_W-1:0] key_in,
    output logic              key_load,
    input  logic [DATA_W-1:0] state_q,
    input  logic [DATA_W-1:0] round_out,
    output logic [DATA_W-1:0] state_d,
    output logic [3:0]        round_idx,
    output logic              final_round,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ciphertext,
    output logic [1:0]        fsm_state
);

    // Handshakes: a transfer happens at a rising edge where valid and ready are both 1;
    // a source keeps its payload stable while valid=1 and ready=0.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    fsm_t              state_r;
    fsm_t              state_nx;
    logic [3:0]        idx_nx;
    logic              ov_nx;
    logic [DATA_W-1:0] ct_nx;
    logic              is_last;

    assign fsm_state = state_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            round_idx  <= 4'd0;
            out_valid  <= 1'b0;
            ciphertext <= '0;
        end else begin
            state_r    <= state_nx;
            round_idx  <= idx_nx;
            out_valid  <= ov_nx;
            ciphertext <= ct_nx;
        end
    end

    always_comb begin
        state_nx    = state_r;
        idx_nx      = round_idx;
        ov_nx       = out_valid;
        ct_nx       = ciphertext;
        in_ready    = 1'b0;
        key_load    = 1'b0;
        state_d     = state_q;
        final_round = 1'b0;
        is_last     = (round_idx == LAST_ROUND);

        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Initial AddRoundKey goes straight into the state register.
                    state_d  = plaintext ^ key_in;
                    key_load = 1'b1;
                    idx_nx   = 4'd1;
                    state_nx = ROUND;
                end
            end
            ROUND: begin
                state_d     = round_out;
                final_round = is_last;
                if (is_last) begin
                    ct_nx    = round_out;
                    ov_nx    = 1'b1;
                    idx_nx   = 4'd0;
                    state_nx = HOLD;
                end else begin
                    idx_nx = round_idx + 4'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    ov_nx    = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = 4'd0;
                ov_nx    = 1'b0;
            end
        endcase

        // The external state register has no reset; feeding zeros flushes it.
        if (rst) begin
            state_d  = '0;
            key_load = 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: attaches a behavioural AES-128 round datapath and key
// schedule, and checks sequencing, backpressure, reset and ciphertexts against an AES model.
module tb_aes_round_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key_in;
    logic         key_load;
    logic [127:0] state_q;
    logic [127:0] round_out;
    logic [127:0] state_d;
    logic [3:0]   round_idx;
    logic         final_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic [1:0]   fsm_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [127:0] exp_q[$];
    logic [1407:0] rk_all;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    aes_round_sequencer #(.NUM_ROUNDS(10), .DATA_W(128)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key_in(key_in), .key_load(key_load),
        .state_q(state_q), .round_out(round_out), .state_d(state_d),
        .round_idx(round_idx), .final_round(final_round), .out_valid(out_valid),
        .out_ready(out_ready), .ciphertext(ciphertext), .fsm_state(fsm_state)
    );

    // ---------------- AES-128 behavioural functions ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq = x;
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        if (x == 8'h00) inv = 8'h00;
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++) t[rw+4*c] = b[rw+4*((c+rw)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                logic [7:0] a0, a1, a2, a3;
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return r ^ k;
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tw;
        logic [7:0]  rcon = 8'h01;
        logic [1407:0] ks;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {tw[23:0], tw[31:24]};
                tw = {sbox(tw[31:24]), sbox(tw[23:16]), sbox(tw[15:8]), sbox(tw[7:0])}
                     ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int r = 0; r < 11; r++) ks[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [1407:0] ks = expand(key);
        logic [127:0] s = pt ^ ks[127:0];
        for (int r = 1; r <= 10; r++) s = aes_round(s, ks[r*128 +: 128], r == 10);
        return s;
    endfunction

    // ---------------- attached datapath: state register, key schedule, round logic ----------------
    always @(posedge clk) begin
        state_q <= state_d;
        if (key_load) rk_all <= expand(key_in);
    end

    always_comb round_out = aes_round(state_q, rk_all[round_idx*128 +: 128], final_round);

    // ---------------- checking / driver tasks ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Entered just after a negedge with the DUT idle; leaves just after the negedge
    // that follows the output handshake.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] exp_ct, input int hold, output int acc);
        logic [127:0] ct_seen;
        logic [127:0] exp;
        check("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        plaintext = pt;
        key_in    = key;
        out_ready = 1'b0;
        #1;
        check("key_load_accept", key_load, 1);
        check("state_d_ark", state_d, pt ^ key);
        exp_q.push_back(exp_ct);
        @(posedge clk);
        #1;
        acc = cyc;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            plaintext = rnd128();
            key_in    = rnd128();
            if (k == 9 && hold == 0) out_ready = 1'b1;
            #1;
            check("round_idx", round_idx, k + 1);
            check("final_round", final_round, k == 9);
            check("key_load_round", key_load, 0);
            check("in_ready_round", in_ready, 0);
            check("out_valid_round", out_valid, 0);
            check("state_d_round", state_d, round_out);
        end
        @(negedge clk);
        #1;
        exp = exp_q.pop_front();
        check("out_valid_latency", out_valid, (cyc - acc) == 10);
        check("ciphertext", ciphertext, exp);
        check("round_idx_hold", round_idx, 0);
        ct_seen = ciphertext;
        for (int j = 1; j <= hold; j++) begin
            @(negedge clk);
            plaintext = rnd128();
            #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_ciphertext", ciphertext, ct_seen);
            check("hold_in_ready", in_ready, 0);
            check("hold_key_load", key_load, 0);
            if (j == hold) out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("out_valid_after_hs", out_valid, 0);
        check("in_ready_after_hs", in_ready, 1);
    endtask

    // ---------------- stimulus ----------------
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    initial begin
        int acc1, acc2;
        logic [127:0] pt, key;
        rst = 1'b1; in_valid = 1'b0; plaintext = '0; key_in = '0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        check("reset_state_d", state_d, 0);
        check("reset_key_load", key_load, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_round_idx", round_idx, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_ciphertext", ciphertext, 0);
        check("reset_in_ready", in_ready, 1);

        // FIPS-197 vector with sequencing and ignored in_valid during ROUND/HOLD.
        run_block(FIPS_PT, FIPS_KEY, FIPS_CT, 0, acc1);
        // Backpressure for 20 cycles.
        run_block(FIPS_PT ^ 128'h1, FIPS_KEY, aes_encrypt(FIPS_PT ^ 128'h1, FIPS_KEY), 20, acc1);

        // Reset mid-ROUND at round_idx=5 discards the block.
        in_valid = 1'b1; plaintext = rnd128(); key_in = rnd128(); out_ready = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            plaintext = rnd128();
        end
        #1;
        check("pre_reset_round_idx", round_idx, 5);
        rst = 1'b1; in_valid = 1'b0;
        #1;
        check("mid_reset_state_d", state_d, 0);
        check("mid_reset_key_load", key_load, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_round_idx", round_idx, 0);
        check("post_reset_out_valid", out_valid, 0);
        check("post_reset_ciphertext", ciphertext, 0);
        check("post_reset_in_ready", in_ready, 1);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            #1;
            check("no_out_valid_after_reset", out_valid, 0);
        end

        // Back-to-back: FIPS vector then all-zero key/plaintext.
        run_block(FIPS_PT, FIPS_KEY, FIPS_CT, 0, acc1);
        run_block('0, '0, ZERO_CT, 0, acc2);
        check("accept_spacing", acc2 - acc1, 12);

        // Random pairs with random backpressure against the AES model.
        for (int n = 0; n < 4; n++) begin
            pt  = rnd128();
            key = rnd128();
            run_block(pt, key, aes_encrypt(pt, key), $urandom_range(0, 5), acc1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
